plic: RTL and testbench

PLIC -- requirements
Module: plic

---
 rtl/plic_pkg.sv | 21 ++
 rtl/plic_arbiter.sv | 29 ++
 rtl/plic.sv | 138 +++++++++++++
 tb/tb_plic.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared constants and types for the PLIC: register byte offsets, default sizing
// and the bus handshake states.
package plic_pkg;

    localparam int NSOURCES_DEFAULT   = 8;
    localparam int NPRIO_BITS_DEFAULT = 3;
    localparam int ID_W               = 5;

    localparam logic [5:0] ADDR_PENDING       = 6'h00;
    localparam logic [5:0] ADDR_ENABLE        = 6'h04;
    localparam logic [5:0] ADDR_THRESHOLD     = 6'h08;
    localparam logic [5:0] ADDR_CLAIM         = 6'h0C;
    localparam logic [5:0] ADDR_PRIORITY_BASE = 6'h10;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACK,
        BUS_WAIT
    } bus_state_t;

endpackage

// File: rtl/plic_arbiter.sv
// Combinational winner select: highest priority among eligible sources, lowest
// index on ties. Reports ID 0 and priority 0 when nothing is eligible.
module plic_arbiter
    import plic_pkg::*;
#(
    parameter int NSOURCES   = NSOURCES_DEFAULT,
    parameter int NPRIO_BITS = NPRIO_BITS_DEFAULT
) (
    input  logic [NSOURCES-1:0]                 eligible,
    input  logic [NSOURCES-1:0][NPRIO_BITS-1:0] prio,
    output logic [ID_W-1:0]                     winner_id,
    output logic [NPRIO_BITS-1:0]               winner_prio
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        winner_id   = '0;
        winner_prio = '0;
        // Eligible sources always have nonzero priority, so a strict compare against
        // the running best both skips empty slots and keeps the lowest index on ties.
        for (int n = 0; n < NSOURCES; n++) begin
            if (eligible[n] && (prio[n] > winner_prio)) begin
                winner_id   = ID_W'(n + 1);
                winner_prio = prio[n];
            end
        end
    end

endmodule

// File: rtl/plic.sv
// Platform-level interrupt controller: per-source gateways, memory-mapped
// enable/threshold/priority registers, claim/complete and a 4-phase bus handshake.
module plic
    import plic_pkg::*;
#(
    parameter int NSOURCES   = NSOURCES_DEFAULT,
    parameter int NPRIO_BITS = NPRIO_BITS_DEFAULT
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NSOURCES-1:0] i_interrupts,
    output logic                o_interrupt,
    input  logic                i_request,
    input  logic                i_rw,
    input  logic [5:0]          i_address,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_rdata,
    output logic                o_ready
);

    logic [NSOURCES-1:0]                 pending;
    logic [NSOURCES-1:0]                 claimed;
    logic [NSOURCES-1:0]                 enable;
    logic [NPRIO_BITS-1:0]               threshold;
    logic [NSOURCES-1:0][NPRIO_BITS-1:0] prio;
    logic [NSOURCES-1:0]                 eligible;
    logic [ID_W-1:0]                     winner_id;
    logic [NPRIO_BITS-1:0]               winner_prio;
    bus_state_t                          state;

    logic                access;
    logic [3:0]          word;
    logic                claim_rd;
    logic                complete_wr;
    logic [NSOURCES-1:0] claim_vec;
    logic [NSOURCES-1:0] complete_vec;
    logic [31:0]         rdata_mux;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^i_address[1:0];
    assign word             = i_address[5:2];
    // An access is taken only in IDLE, so a held request has its side effects once.
    assign access           = (state == BUS_IDLE) && i_request;
    assign claim_rd         = access && !i_rw && (word == ADDR_CLAIM[5:2]);
    assign complete_wr      = access &&  i_rw && (word == ADDR_CLAIM[5:2]);

    always_comb begin
        eligible     = '0;
        claim_vec    = '0;
        complete_vec = '0;
        for (int n = 0; n < NSOURCES; n++) begin
            eligible[n]     = pending[n] && enable[n] && (prio[n] != '0);
            claim_vec[n]    = claim_rd && (winner_id == ID_W'(n + 1));
            complete_vec[n] = complete_wr && (i_wdata == 32'(n + 1));
        end
    end

    plic_arbiter #(
        .NSOURCES   (NSOURCES),
        .NPRIO_BITS (NPRIO_BITS)
    ) u_arbiter (
        .eligible    (eligible),
        .prio        (prio),
        .winner_id   (winner_id),
        .winner_prio (winner_prio)
    );

    always_comb begin
        rdata_mux = '0;
        case (word)
            ADDR_PENDING[5:2]:   rdata_mux = 32'(pending);
            ADDR_ENABLE[5:2]:    rdata_mux = 32'(enable);
            ADDR_THRESHOLD[5:2]: rdata_mux = 32'(threshold);
            ADDR_CLAIM[5:2]:     rdata_mux = 32'(winner_id);
            default: begin
                for (int n = 0; n < NSOURCES; n++) begin
                    if (int'(word) == int'(ADDR_PRIORITY_BASE[5:2]) + n) begin
                        rdata_mux = 32'(prio[n]);
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // NOTE: the priority array is architectural state and is cleared here like any register.
            pending     <= '0;
            claimed     <= '0;
            enable      <= '0;
            threshold   <= '0;
            prio        <= '0;
            state       <= BUS_IDLE;
            o_ready     <= 1'b0;
            o_rdata     <= '0;
            o_interrupt <= 1'b0;
        end else begin
            o_interrupt <= (winner_prio > threshold);
            // Claim wins over a coincident gateway set on the same source.
            pending     <= (pending & ~claim_vec)
                         | (i_interrupts & ~claimed & ~pending & ~claim_vec);
            claimed     <= (claimed | claim_vec) & ~complete_vec;

            case (state)
                BUS_IDLE: begin
                    if (i_request) begin
                        state   <= BUS_ACK;
                        o_ready <= 1'b1;
                        o_rdata <= i_rw ? 32'd0 : rdata_mux;
                    end
                end
                BUS_ACK: begin
                    o_ready <= i_request;
                    state   <= BUS_WAIT;
                end
                BUS_WAIT: begin
                    if (!i_request) begin
                        o_ready <= 1'b0;
                        state   <= BUS_IDLE;
                    end
                end
                default: state <= BUS_IDLE;
            endcase

            if (access && i_rw) begin
                if (word == ADDR_ENABLE[5:2])    enable    <= i_wdata[NSOURCES-1:0];
                if (word == ADDR_THRESHOLD[5:2]) threshold <= i_wdata[NPRIO_BITS-1:0];
                for (int n = 0; n < NSOURCES; n++) begin
                    if (int'(word) == int'(ADDR_PRIORITY_BASE[5:2]) + n) begin
                        prio[n] <= i_wdata[NPRIO_BITS-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_plic.sv
// Directed bench for plic: accesses push their expected read data into a
// scoreboard queue that a separate monitor drains on each rising o_ready.
module tb_plic;
    import plic_pkg::*;

    localparam int NS = 8;
    localparam int NP = 3;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic [NS-1:0] i_interrupts;
    logic          o_interrupt;
    logic          i_request;
    logic          i_rw;
    logic [5:0]    i_address;
    logic [31:0]   i_wdata;
    logic [31:0]   o_rdata;
    logic          o_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        ready_q = 1'b0;

    always #5 i_clock = ~i_clock;

    plic #(
        .NSOURCES   (NS),
        .NPRIO_BITS (NP)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_interrupts (i_interrupts),
        .o_interrupt  (o_interrupt),
        .i_request    (i_request),
        .i_rw         (i_rw),
        .i_address    (i_address),
        .i_wdata      (i_wdata),
        .o_rdata      (o_rdata),
        .o_ready      (o_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every new o_ready presents one access result.
    always @(negedge i_clock) begin
        if (o_ready && !ready_q) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rdata_unexpected: got 0x%08h with no access outstanding", o_rdata);
            end else begin
                check(name_q.pop_front(), o_rdata, exp_q.pop_front());
            end
        end
        ready_q = o_ready;
    end

    function automatic logic [5:0] pa(input int n);
        return 6'(16 + 4 * n);
    endfunction

    task automatic bus(input logic rw, input logic [5:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        i_request = 1'b1;
        i_rw      = rw;
        i_address = addr;
        i_wdata   = wdata;
        for (int k = 0; k < 8 && !o_ready; k++) @(negedge i_clock);
        check({name, "_ready"}, 32'(o_ready), 32'd1);
        i_request = 1'b0;
        @(negedge i_clock);
        @(negedge i_clock);
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        bus(1'b1, addr, data, 32'd0, $sformatf("wr_%02h", addr));
    endtask

    task automatic rd(input logic [5:0] addr, input logic [31:0] exp, input string name);
        bus(1'b0, addr, 32'd0, exp, name);
    endtask

    task automatic pulse(input logic [NS-1:0] srcs);
        i_interrupts = srcs;
        @(negedge i_clock);
        i_interrupts = '0;
        @(negedge i_clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        i_reset      = 1'b1;
        i_interrupts = '0;
        i_request    = 1'b0;
        i_rw         = 1'b0;
        i_address    = '0;
        i_wdata      = '0;
        repeat (2) @(negedge i_clock);
        check("rst_interrupt", 32'(o_interrupt), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        i_reset = 1'b0;
        @(negedge i_clock);
        rd(ADDR_PENDING, 32'h0, "rst_pending");
        rd(ADDR_ENABLE, 32'h0, "rst_enable");
        rd(ADDR_THRESHOLD, 32'h0, "rst_threshold");
        rd(pa(2), 32'h0, "rst_prio2");
        rd(ADDR_CLAIM, 32'h0, "rst_claim");

        // Register widths, unmapped space, read-only PENDING, ignored byte bits.
        wr(ADDR_ENABLE, 32'hFFFF_FFFF);
        rd(ADDR_ENABLE, 32'h0000_00FF, "enable_width");
        rd(6'h07, 32'h0000_00FF, "enable_byte_addr");
        wr(ADDR_THRESHOLD, 32'hFFFF_FFFF);
        rd(ADDR_THRESHOLD, 32'h7, "threshold_width");
        wr(pa(8), 32'h7);
        rd(pa(8), 32'h0, "unmapped_prio8");
        wr(ADDR_PENDING, 32'hFF);
        rd(ADDR_PENDING, 32'h0, "pending_ro");

        // Single pulsed source through claim and complete.
        wr(ADDR_THRESHOLD, 32'h0);
        wr(pa(2), 32'h5);
        wr(ADDR_ENABLE, 32'h04);
        rd(pa(2), 32'h5, "prio2_rw");
        i_interrupts = 8'h04;
        @(negedge i_clock);
        i_interrupts = '0;
        check("irq_not_yet", 32'(o_interrupt), 32'd0);
        @(negedge i_clock);
        check("irq_raised", 32'(o_interrupt), 32'd1);
        rd(ADDR_PENDING, 32'h04, "t1_pending");
        rd(ADDR_CLAIM, 32'd3, "t1_claim");
        check("irq_dropped", 32'(o_interrupt), 32'd0);
        rd(ADDR_PENDING, 32'h0, "t1_pending_cleared");
        wr(ADDR_CLAIM, 32'd3);
        pulse(8'h04);
        rd(ADDR_PENDING, 32'h04, "t1_repend_after_complete");
        rd(ADDR_CLAIM, 32'd3, "t1_claim2");
        wr(ADDR_CLAIM, 32'd3);

        // Priority order and lowest-index tie break.
        wr(pa(0), 32'h3);
        wr(pa(4), 32'h3);
        wr(pa(6), 32'h7);
        wr(ADDR_ENABLE, 32'h51);
        i_interrupts = 8'h51;
        repeat (2) @(negedge i_clock);
        check("t2_irq", 32'(o_interrupt), 32'd1);
        rd(ADDR_PENDING, 32'h51, "t2_pending");
        rd(ADDR_CLAIM, 32'd7, "t2_claim_a");
        rd(ADDR_CLAIM, 32'd1, "t2_claim_b");
        rd(ADDR_CLAIM, 32'd5, "t2_claim_c");
        rd(ADDR_CLAIM, 32'd0, "t2_claim_none");
        rd(ADDR_PENDING, 32'h0, "t2_no_repend_claimed");
        i_interrupts = '0;
        wr(ADDR_CLAIM, 32'd7);
        wr(ADDR_CLAIM, 32'd1);
        wr(ADDR_CLAIM, 32'd5);
        rd(ADDR_PENDING, 32'h0, "t2_pending_idle");

        // Threshold is a strict compare and does not gate claim.
        wr(ADDR_ENABLE, 32'h02);
        wr(pa(1), 32'h5);
        wr(ADDR_THRESHOLD, 32'h5);
        pulse(8'h02);
        check("t3_irq_at_threshold", 32'(o_interrupt), 32'd0);
        rd(ADDR_CLAIM, 32'd2, "t3_claim_below");
        wr(ADDR_CLAIM, 32'd2);
        wr(ADDR_THRESHOLD, 32'h4);
        pulse(8'h02);
        check("t3_irq_above", 32'(o_interrupt), 32'd1);
        rd(ADDR_CLAIM, 32'd2, "t3_claim_above");
        wr(ADDR_CLAIM, 32'd2);
        wr(ADDR_THRESHOLD, 32'h0);

        // Held source: no re-pend while claimed, re-pends after complete.
        i_interrupts = 8'h02;
        repeat (2) @(negedge i_clock);
        rd(ADDR_CLAIM, 32'd2, "t4_claim");
        rd(ADDR_PENDING, 32'h0, "t4_held_claimed");
        wr(ADDR_CLAIM, 32'd2);
        rd(ADDR_PENDING, 32'h02, "t4_repend");
        i_interrupts = '0;
        rd(ADDR_CLAIM, 32'd2, "t4_claim2");
        wr(ADDR_CLAIM, 32'd2);

        // Claim with request held for 10 cycles.
        wr(pa(3), 32'h2);
        wr(ADDR_ENABLE, 32'h0A);
        pulse(8'h0A);
        exp_q.push_back(32'd2);
        name_q.push_back("t5_claim_long");
        i_request = 1'b1;
        i_rw      = 1'b0;
        i_address = ADDR_CLAIM;
        for (int k = 1; k <= 9; k++) begin
            @(negedge i_clock);
            check($sformatf("t5_ready_cycle%0d", k + 1), 32'(o_ready), 32'd1);
        end
        @(negedge i_clock);
        i_request = 1'b0;
        @(negedge i_clock);
        check("t5_ready_release", 32'(o_ready), 32'd0);
        @(negedge i_clock);
        rd(ADDR_PENDING, 32'h08, "t5_single_claim");
        rd(ADDR_CLAIM, 32'd4, "t5_second");
        wr(ADDR_CLAIM, 32'd2);
        wr(ADDR_CLAIM, 32'd4);

        // Bogus completes change nothing.
        wr(ADDR_ENABLE, 32'h05);
        i_interrupts = 8'h05;
        repeat (2) @(negedge i_clock);
        rd(ADDR_CLAIM, 32'd3, "t6_claim_a");
        rd(ADDR_CLAIM, 32'd1, "t6_claim_b");
        wr(ADDR_CLAIM, 32'd0);
        wr(ADDR_CLAIM, 32'd9);
        wr(ADDR_CLAIM, 32'd2);
        rd(ADDR_PENDING, 32'h0, "t6_bogus_complete");
        wr(ADDR_CLAIM, 32'd3);
        rd(ADDR_PENDING, 32'h04, "t6_complete3");
        wr(ADDR_CLAIM, 32'd1);
        rd(ADDR_PENDING, 32'h05, "t6_complete1");
        i_interrupts = '0;
        wr(ADDR_THRESHOLD, 32'h3);
        check("t6_irq_before_reset", 32'(o_interrupt), 32'd1);

        // Reset while the access is in ACK.
        exp_q.push_back(32'h05);
        name_q.push_back("t6_abort_read");
        i_request = 1'b1;
        i_rw      = 1'b0;
        i_address = ADDR_PENDING;
        @(negedge i_clock);
        check("t6_in_ack", 32'(o_ready), 32'd1);
        i_reset   = 1'b1;
        i_request = 1'b0;
        @(negedge i_clock);
        check("t6_rst_ready", 32'(o_ready), 32'd0);
        check("t6_rst_rdata", o_rdata, 32'd0);
        check("t6_rst_irq", 32'(o_interrupt), 32'd0);
        i_reset = 1'b0;
        @(negedge i_clock);
        rd(ADDR_PENDING, 32'h0, "t6_pending_after_rst");
        rd(ADDR_ENABLE, 32'h0, "t6_enable_after_rst");
        rd(ADDR_THRESHOLD, 32'h0, "t6_threshold_after_rst");
        rd(pa(2), 32'h0, "t6_prio2_after_rst");
        rd(pa(6), 32'h0, "t6_prio6_after_rst");
        rd(ADDR_CLAIM, 32'h0, "t6_claim_after_rst");

        repeat (2) @(negedge i_clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
